// File: rtl/dcache_refill.sv
`default_nettype none
// ============================================================================
// Module  : dcache_refill
// Brief   : Line-refill miss handler feeding the data cache load port.
// Rev     : 1.0  initial release
// ============================================================================
module dcache_refill #(
  parameter int MEM_SCALE = 27,
  parameter int LINE_LOG  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_req,
  input  logic [MEM_SCALE-1:0] miss_addr,
  input  logic [3:0]           cpu_we,
  output logic                 miss_done,
  output logic                 busy,
  output logic                 dram_req_valid,
  input  logic                 dram_req_ready,
  output logic [MEM_SCALE-1:0] dram_req_addr,
  input  logic                 dram_rsp_valid,
  output logic                 dram_rsp_ready,
  input  logic [31:0]          dram_rsp_data,
  output logic                 load_oe,
  output logic [MEM_SCALE-1:0] load_addr,
  output logic [31:0]          load_wdata,
  output logic [3:0]           load_we,
  output logic [31:0]          refill_count
);

  // A one-word line still needs a one-bit counter to keep the datapath legal.
  localparam int                   c_cnt_w     = (LINE_LOG > 0) ? LINE_LOG : 1;
  localparam logic [c_cnt_w-1:0]   c_last      = c_cnt_w'((1 << LINE_LOG) - 1);
  localparam logic [MEM_SCALE-1:0] c_line_mask = ~(MEM_SCALE'((1 << (LINE_LOG + 2)) - 1));

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_req  = 2'd1;
  localparam logic [1:0] c_fill = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  logic [1:0]           state_q,        state_d;
  logic [MEM_SCALE-1:0] base_q,         base_d;
  logic [c_cnt_w-1:0]   cnt_q,          cnt_d;
  logic [31:0]          refill_count_q, refill_count_d;
  logic                 w_fire;

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    cnt_d          = cnt_q;
    refill_count_d = refill_count_q;
    w_fire         = 1'b0;
    dram_req_valid = 1'b0;
    dram_req_addr  = '0;
    dram_rsp_ready = 1'b0;
    load_oe        = 1'b0;
    load_addr      = '0;
    load_wdata     = '0;
    load_we        = 4'h0;
    miss_done      = 1'b0;

    case (state_q)
      c_idle: begin
        if (miss_req) begin
          base_d  = miss_addr & c_line_mask;
          cnt_d   = '0;
          state_d = c_req;
        end
      end
      c_req: begin
        dram_req_valid = 1'b1;
        dram_req_addr  = base_q;
        if (dram_req_ready) begin
          state_d = c_fill;
        end
      end
      c_fill: begin
        // Any active store byte lane blocks the load port, so partial stores
        // can never collide with a refill write either.
        dram_rsp_ready = ~|cpu_we;
        w_fire         = dram_rsp_valid & dram_rsp_ready;
        if (w_fire) begin
          load_oe    = 1'b1;
          load_we    = 4'hF;
          load_addr  = base_q | MEM_SCALE'({cnt_q, 2'b00});
          load_wdata = dram_rsp_data;
          cnt_d      = cnt_q + c_cnt_w'(1);
          if (cnt_q == c_last) begin
            state_d = c_done;
          end
        end
      end
      c_done: begin
        miss_done      = 1'b1;
        refill_count_d = refill_count_q + 32'd1;
        state_d        = c_idle;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= c_idle;
      base_q         <= '0;
      cnt_q          <= '0;
      refill_count_q <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      cnt_q          <= cnt_d;
      refill_count_q <= refill_count_d;
    end
  end

  assign busy         = (state_q != c_idle);
  assign refill_count = refill_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_refill.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_refill
// Brief   : Scoreboard bench for dcache_refill (4-word and 1-word line builds).
// Rev     : 1.0  initial release
// ============================================================================
module tb_dcache_refill;

  logic        clk;
  logic        rst;
  logic        miss_req;
  logic [26:0] miss_addr;
  logic [3:0]  cpu_we;
  logic        miss_done;
  logic        busy;
  logic        dram_req_valid;
  logic        dram_req_ready;
  logic [26:0] dram_req_addr;
  logic        dram_rsp_valid;
  logic        dram_rsp_ready;
  logic [31:0] dram_rsp_data;
  logic        load_oe;
  logic [26:0] load_addr;
  logic [31:0] load_wdata;
  logic [3:0]  load_we;
  logic [31:0] refill_count;

  logic        miss_req1;
  logic [26:0] miss_addr1;
  logic [3:0]  cpu_we1;
  logic        miss_done1;
  logic        busy1;
  logic        dram_req_valid1;
  logic        dram_req_ready1;
  logic [26:0] dram_req_addr1;
  logic        dram_rsp_valid1;
  logic        dram_rsp_ready1;
  logic [31:0] dram_rsp_data1;
  logic        load_oe1;
  logic [26:0] load_addr1;
  logic [31:0] load_wdata1;
  logic [3:0]  load_we1;
  logic [31:0] refill_count1;

  int          n_checks;
  int          n_errors;
  int          exp_refills;
  logic [58:0] exp_q[$];
  logic [58:0] exp_e;

  dcache_refill #(.MEM_SCALE(27), .LINE_LOG(2)) u_dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .cpu_we(cpu_we),
    .miss_done(miss_done), .busy(busy), .dram_req_valid(dram_req_valid),
    .dram_req_ready(dram_req_ready), .dram_req_addr(dram_req_addr),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_ready(dram_rsp_ready),
    .dram_rsp_data(dram_rsp_data), .load_oe(load_oe), .load_addr(load_addr),
    .load_wdata(load_wdata), .load_we(load_we), .refill_count(refill_count)
  );

  dcache_refill #(.MEM_SCALE(27), .LINE_LOG(0)) u_dut_w1 (
    .clk(clk), .rst(rst), .miss_req(miss_req1), .miss_addr(miss_addr1), .cpu_we(cpu_we1),
    .miss_done(miss_done1), .busy(busy1), .dram_req_valid(dram_req_valid1),
    .dram_req_ready(dram_req_ready1), .dram_req_addr(dram_req_addr1),
    .dram_rsp_valid(dram_rsp_valid1), .dram_rsp_ready(dram_rsp_ready1),
    .dram_rsp_data(dram_rsp_data1), .load_oe(load_oe1), .load_addr(load_addr1),
    .load_wdata(load_wdata1), .load_we(load_we1), .refill_count(refill_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load-port monitor: every write must match the scoreboard head.
  always @(negedge clk) begin
    chk_eq("we_exclusive", 64'((load_we != 4'h0) && (cpu_we != 4'h0)), 64'd0);
    if (load_we != 4'h0) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_write", 64'({load_addr, load_wdata}), 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk_eq("load_addr", 64'(load_addr), 64'(exp_e[58:32]));
        chk_eq("load_wdata", 64'(load_wdata), 64'(exp_e[31:0]));
        chk_eq("load_we", 64'(load_we), 64'hF);
        chk_eq("load_oe", 64'(load_oe), 64'd1);
      end
    end
  end

  task automatic start_miss(input logic [26:0] addr);
    @(posedge clk) #1;
    miss_req  = 1'b1;
    miss_addr = addr;
    @(posedge clk) #1;
  endtask

  // Entered one step after the edge that moved the DUT into REQ.
  task automatic run_refill(input logic [26:0] addr, input logic [31:0] d0, input int req_stall,
                            input int bp_word, input int bp_cycles, input bit hold);
    logic [26:0] base;
    base = addr & ~27'hF;
    dram_req_ready = 1'b0;
    for (int i = 0; i < req_stall; i++) begin
      @(negedge clk);
      chk_eq("req_valid_stall", 64'(dram_req_valid), 64'd1);
      chk_eq("req_addr_stall", 64'(dram_req_addr), 64'(base));
      @(posedge clk) #1;
    end
    dram_req_ready = 1'b1;
    @(negedge clk);
    chk_eq("req_valid", 64'(dram_req_valid), 64'd1);
    chk_eq("req_addr", 64'(dram_req_addr), 64'(base));
    chk_eq("rsp_ready_req", 64'(dram_rsp_ready), 64'd0);
    @(posedge clk) #1;
    dram_req_ready = 1'b0;
    @(negedge clk);
    chk_eq("fill_entry_valid", 64'(dram_req_valid), 64'd0);
    chk_eq("fill_entry_ready", 64'(dram_rsp_ready), 64'd1);
    @(posedge clk) #1;
    for (int w = 0; w < 4; w++) begin
      dram_rsp_valid = 1'b1;
      dram_rsp_data  = d0 + 32'(w);
      if (w == bp_word) begin
        cpu_we = 4'hF;
        for (int c = 0; c < bp_cycles; c++) begin
          @(negedge clk);
          chk_eq("bp_rsp_ready", 64'(dram_rsp_ready), 64'd0);
          chk_eq("bp_load_we", 64'(load_we), 64'd0);
          @(posedge clk) #1;
        end
        cpu_we = 4'h0;
      end
      exp_q.push_back({base | 27'(w * 4), d0 + 32'(w)});
      @(negedge clk);
      @(posedge clk) #1;
    end
    dram_rsp_valid = 1'b0;
    if (!hold) miss_req = 1'b0;
    exp_refills++;
    @(negedge clk);
    chk_eq("miss_done", 64'(miss_done), 64'd1);
    chk_eq("busy_done", 64'(busy), 64'd1);
    chk_eq("rsp_ready_done", 64'(dram_rsp_ready), 64'd0);
    chk_eq("writes_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk) #1;
    @(negedge clk);
    chk_eq("miss_done_pulse", 64'(miss_done), 64'd0);
    chk_eq("busy_idle", 64'(busy), 64'd0);
    chk_eq("refill_count", 64'(refill_count), 64'(exp_refills));
    if (hold) @(posedge clk) #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; exp_refills = 0;
    rst = 1'b0;
    miss_req = 1'b0; miss_addr = '0; cpu_we = 4'h0;
    dram_req_ready = 1'b0; dram_rsp_valid = 1'b0; dram_rsp_data = '0;
    miss_req1 = 1'b0; miss_addr1 = '0; cpu_we1 = 4'h0;
    dram_req_ready1 = 1'b0; dram_rsp_valid1 = 1'b0; dram_rsp_data1 = '0;
    #2;
    chk_eq("reset_outputs", 64'({busy, miss_done, dram_req_valid, dram_rsp_ready, load_oe, load_we}), 64'd0);
    chk_eq("reset_count", 64'(refill_count), 64'd0);
    chk_eq("reset_addrs", 64'({dram_req_addr, load_addr} | 54'(load_wdata)), 64'd0);
    @(posedge clk) #1;
    rst = 1'b1;

    // Basic refill, then store back-pressure on the second word.
    start_miss(27'h0001234);
    run_refill(27'h0001234, 32'hA0, 0, -1, 0, 1'b0);
    start_miss(27'h0001234);
    run_refill(27'h0001234, 32'hC0, 0, 1, 3, 1'b0);

    // Request held off for five cycles.
    start_miss(27'h0002008);
    run_refill(27'h0002008, 32'hD0, 5, -1, 0, 1'b0);

    // Responses offered while idle must be ignored.
    dram_rsp_valid = 1'b1;
    dram_rsp_data  = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("idle_rsp_ready", 64'(dram_rsp_ready), 64'd0);
      chk_eq("idle_busy", 64'(busy), 64'd0);
      @(posedge clk) #1;
    end
    dram_rsp_valid = 1'b0;

    // miss_req lingering into IDLE starts a second refill.
    start_miss(27'h0000108);
    run_refill(27'h0000108, 32'h10, 0, -1, 0, 1'b1);
    run_refill(27'h0000108, 32'h20, 0, 2, 1, 1'b0);

    // Asynchronous reset after two words of a fill.
    start_miss(27'h0000800);
    dram_req_ready = 1'b1;
    @(posedge clk) #1;
    dram_req_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      dram_rsp_valid = 1'b1;
      dram_rsp_data  = 32'hE0 + 32'(w);
      exp_q.push_back({27'h800 | 27'(w * 4), 32'hE0 + 32'(w)});
      @(posedge clk) #1;
    end
    dram_rsp_valid = 1'b0;
    #2;
    rst = 1'b0;
    miss_req = 1'b0;
    dram_rsp_valid = 1'b1;
    dram_rsp_data  = 32'hE2;
    #1;
    chk_eq("async_rst_outputs", 64'({busy, miss_done, dram_req_valid, dram_rsp_ready, load_oe, load_we}), 64'd0);
    chk_eq("async_rst_count", 64'(refill_count), 64'd0);
    chk_eq("async_rst_load_addr", 64'(load_addr), 64'd0);
    @(posedge clk) #1;
    rst = 1'b1;
    dram_rsp_valid = 1'b0;
    exp_refills = 0;
    @(negedge clk);
    chk_eq("post_rst_busy", 64'(busy), 64'd0);
    chk_eq("post_rst_count", 64'(refill_count), 64'd0);
    start_miss(27'h0000040);
    run_refill(27'h0000040, 32'hF0, 0, -1, 0, 1'b0);

    // One-word-line build at the top of the address space.
    @(posedge clk) #1;
    miss_req1 = 1'b1;
    miss_addr1 = 27'h7FFFFFC;
    @(posedge clk) #1;
    dram_req_ready1 = 1'b1;
    @(negedge clk);
    chk_eq("w1_req_valid", 64'(dram_req_valid1), 64'd1);
    chk_eq("w1_req_addr", 64'(dram_req_addr1), 64'h7FFFFFC);
    @(posedge clk) #1;
    dram_req_ready1 = 1'b0;
    dram_rsp_valid1 = 1'b1;
    dram_rsp_data1  = 32'hB0;
    @(negedge clk);
    chk_eq("w1_load_we", 64'(load_we1), 64'hF);
    chk_eq("w1_load_addr", 64'(load_addr1), 64'h7FFFFFC);
    chk_eq("w1_load_wdata", 64'(load_wdata1), 64'hB0);
    @(posedge clk) #1;
    dram_rsp_valid1 = 1'b0;
    miss_req1 = 1'b0;
    @(negedge clk);
    chk_eq("w1_load_we_done", 64'(load_we1), 64'd0);
    chk_eq("w1_miss_done", 64'(miss_done1), 64'd1);
    @(posedge clk) #1;
    @(negedge clk);
    chk_eq("w1_idle", 64'({busy1, miss_done1}), 64'd0);
    chk_eq("w1_refill_count", 64'(refill_count1), 64'd1);

    @(posedge clk) #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
